mips_branch_predictor: RTL and testbench
========================================

Name: mips_branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline; next generation of the static flush-on-resolve control-hazard scheme.
- IF looks up the current PC combinationally and receives a predicted taken/target.
- EX reports resolved branches; the block trains a direct-mapped BTB with saturating counters and flags mispredicts with the correct redirect PC.
- Also keeps branch and mispredict performance counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB/BHT entry count; power of two, >= 2. IDX = log2(ENTRIES).
- CTR_BITS, 2, saturating counter width; >= 1.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous invalidate of all entries.
- lk_pc_i  in  XLEN  IF-stage PC to look up.
- pred_taken_o  out  1  predict taken.
- pred_target_o  out  XLEN  predicted target; lk_pc_i+4 when not taken.
- upd_valid_i  in  1  resolved branch present in EX this cycle.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  XLEN  actual taken target.
- upd_pred_taken_i  in  1  prediction that travelled down the pipe with the branch.
- upd_pred_target_i  in  XLEN  predicted target that travelled with the branch.
- mispredict_o  out  1  flush IF/ID and redirect.
- redirect_pc_o  out  XLEN  correct next PC.
- branch_cnt_o  out  CNT_W  resolved-branch count.
- mispred_cnt_o  out  CNT_W  mispredict count.

Behaviour:
- Entry fields: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:0], ctr[CTR_BITS-1:0]. Index = pc[IDX+1:2]; pc[1:0] is ignored.
- Reset (async): all valid=0; all ctr = WNT = 2^(CTR_BITS-1)-1; both perf counters 0. Outputs go to pred_taken_o=0, pred_target_o=lk_pc_i+4, mispredict_o=0, redirect_pc_o=upd_pc_i+4.
- Lookup is combinational, zero latency. hit = valid & tag match. pred_taken_o = hit & ctr[MSB]. pred_target_o = pred_taken_o ? target : lk_pc_i+4.
- mispredict_o is combinational: upd_valid_i & ((upd_taken_i != upd_pred_taken_i) | (upd_taken_i & upd_target_i != upd_pred_target_i)).
- redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4. Driven every cycle; meaningful only when mispredict_o=1.
- Training happens on the clk edge when upd_valid_i=1 and clear_i=0:
  - Hit, taken: ctr = min(ctr+1, 2^CTR_BITS-1); target = upd_target_i.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate/replace. valid=1, tag, target written, ctr = WT = 2^(CTR_BITS-1).
  - Miss, not taken: no change.
- Simultaneous lookup and update to the same index: lookup returns the pre-edge contents. No bypass.
- clear_i: all valid=0 and ctr=WNT at the next edge. Clear wins over a same-cycle update. Perf counters are not cleared.
- Perf counters:
  - branch_cnt_o += 1 per cycle with upd_valid_i=1.
  - mispred_cnt_o += 1 per cycle with mispredict_o=1.
  - Both wrap modulo 2^CNT_W and are counted regardless of clear_i.
- PC arithmetic (+4) is modulo 2^XLEN.
- Reset mid-operation: all state returns to reset values immediately, without waiting for clk. The first lookup after release predicts not taken.
- Integration: the top drives lk_pc_i=pc_IF. in_pc priority is mispredict_o > pred_target_o.

Test Plan:
- Reset, then lk_pc_i=0x40 -> pred_taken_o=0, pred_target_o=0x44. upd_valid_i=0 -> mispredict_o=0, both counters 0.
- Update pc=0x40, taken, target=0x80, pred_taken=0 -> same cycle mispredict_o=1, redirect_pc_o=0x80. Next cycle lookup 0x40 -> pred_taken_o=1, pred_target_o=0x80. branch_cnt_o=1, mispred_cnt_o=1.
- Counter saturation on entry 0x40:
  - Two more taken updates -> ctr=3.
  - One not-taken -> ctr=2, still predicts taken.
  - Second not-taken -> ctr=1, lookup predicts not taken, pred_target_o=0x44.
- Aliasing: pc 0x40 trained taken, then lookup 0x80 (same index 0, different tag) -> pred_taken_o=0. Update 0x80 taken to 0x100 replaces the entry, and lookup 0x40 now misses.
- Target change: hit on 0x40 with pred_target 0x80, actual taken to 0xC0 -> mispredict_o=1, redirect_pc_o=0xC0. Next lookup gives target 0xC0.
- clear_i with simultaneous taken update for 0x60 -> next cycle lookups of 0x40 and 0x60 both miss. branch_cnt_o still increments.
- CNT_W=4: 16 consecutive mispredicting updates -> both counters wrap to 0.
- rst pulsed between clocks -> table invalidated and counters 0 with no clk edge required.

Source files
------------

// File: rtl/mips_branch_predictor.sv
// rtl/mips_branch_predictor.sv - direct-mapped BTB/BHT dynamic branch predictor
//
// Purpose: zero-latency IF-stage lookup of predicted taken/target, EX-stage
// training of saturating counters, mispredict detection with redirect PC,
// and resolved-branch / mispredict performance counters.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   clear_i             synchronous invalidate of every entry
//   lk_pc_i             IF PC to look up
//   pred_taken_o        predicted taken
//   pred_target_o       predicted next PC (lk_pc_i+4 when not taken)
//   upd_valid_i         resolved branch present in EX
//   upd_pc_i            PC of resolved branch
//   upd_taken_i         actual outcome
//   upd_target_i        actual taken target
//   upd_pred_taken_i    prediction carried with the branch
//   upd_pred_target_i   predicted target carried with the branch
//   mispredict_o        flush IF/ID and redirect
//   redirect_pc_o       correct next PC
//   branch_cnt_o        resolved-branch count (wraps)
//   mispred_cnt_o       mispredict count (wraps)
module mips_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [XLEN-1:0]  lk_pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  // Weakly-taken is the MSB alone; weakly-not-taken is one below it.
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
  logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

  logic [IDX-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;

  assign lk_idx  = lk_pc_i[IDX+1:2];
  assign lk_tag  = lk_pc_i[XLEN-1:IDX+2];
  assign upd_idx = upd_pc_i[IDX+1:2];
  assign upd_tag = upd_pc_i[XLEN-1:IDX+2];

  // Lookup reads registered state only, so a same-edge update is not bypassed.
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : lk_pc_i + XLEN'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign mispredict_o  = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;

    if (clear_i) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_d[i] = CTR_WNT;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          target_d[upd_idx] = upd_target_i;
          if (ctr_q[upd_idx] != CTR_MAX) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_BITS'(1);
          end
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_BITS'(1);
        end
      end else if (upd_taken_i) begin
        // Not-taken misses are never allocated: they would only predict pc+4.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target_i;
        ctr_d[upd_idx]    = CTR_WT;
      end
    end

    // Perf counters run independently of clear_i.
    branch_cnt_d  = branch_cnt_q + CNT_W'(upd_valid_i);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(mispredict_o);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_branch_predictor.sv
// tb/tb_mips_branch_predictor.sv - self-checking bench for mips_branch_predictor
module tb_mips_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CTR_B   = 2;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear_i;
  logic [XLEN-1:0]   lk_pc_i;
  logic              pred_taken_o;
  logic [XLEN-1:0]   pred_target_o;
  logic              upd_valid_i;
  logic [XLEN-1:0]   upd_pc_i;
  logic              upd_taken_i;
  logic [XLEN-1:0]   upd_target_i;
  logic              upd_pred_taken_i;
  logic [XLEN-1:0]   upd_pred_target_i;
  logic              mispredict_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic [CNT_W-1:0]  branch_cnt_o;
  logic [CNT_W-1:0]  mispred_cnt_o;

  mips_branch_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_B), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .lk_pc_i(lk_pc_i), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o), .branch_cnt_o(branch_cnt_o),
    .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one record per table slot, branch identity kept as the
  // PC's upper part, counter as a plain integer 0..3.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int unsigned m_bcnt, m_mcnt;

  // Outputs captured mid-cycle by the last step.
  logic        obs_pt, obs_mp;
  logic [31:0] obs_tgt, obs_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0;
  endfunction

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit model_hit(input int unsigned pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  function automatic bit model_pt(input int unsigned pc);
    return model_hit(pc) && m_ctr[idx_of(pc)] >= 2;
  endfunction

  function automatic int unsigned model_tgt(input int unsigned pc);
    return model_pt(pc) ? m_target[idx_of(pc)] : pc + 4;
  endfunction

  task automatic step(input bit uv, input int unsigned upc, input bit ut,
                      input int unsigned utgt, input bit upt, input int unsigned uptgt,
                      input bit clr, input int unsigned lpc);
    bit          mp;
    int unsigned i;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
    upd_pred_taken_i = upt; upd_pred_target_i = uptgt; clear_i = clr; lk_pc_i = lpc;
    mp = uv && ((ut != upt) || (ut && utgt != uptgt));
    @(negedge clk);
    obs_pt = pred_taken_o; obs_tgt = pred_target_o; obs_mp = mispredict_o; obs_rd = redirect_pc_o;
    check("pred_taken", {31'b0, obs_pt}, {31'b0, model_pt(lpc)});
    check("pred_target", obs_tgt, model_tgt(lpc));
    check("mispredict", {31'b0, obs_mp}, {31'b0, mp});
    if (mp) check("redirect", obs_rd, ut ? utgt : upc + 4);
    @(posedge clk);
    i = idx_of(upc);
    if (clr) begin
      for (int k = 0; k < ENTRIES; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
    end else if (uv) begin
      if (model_hit(upc)) begin
        if (ut) begin
          m_target[i] = utgt;
          if (m_ctr[i] < 3) m_ctr[i]++;
        end else if (m_ctr[i] > 0) m_ctr[i]--;
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upc); m_target[i] = utgt; m_ctr[i] = 2;
      end
    end
    m_bcnt = (m_bcnt + uv) % 16;
    m_mcnt = (m_mcnt + mp) % 16;
    #1;
    check("branch_cnt", {28'b0, branch_cnt_o}, m_bcnt);
    check("mispred_cnt", {28'b0, mispred_cnt_o}, m_mcnt);
  endtask

  // Lookup-only cycle.
  task automatic look(input int unsigned lpc);
    step(0, 0, 0, 0, 0, 0, 0, lpc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int unsigned pc, lp, tgt, ptg;
    bit          t, pt, v, c;

    clear_i = 0; lk_pc_i = 0; upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0;
    upd_target_i = 0; upd_pred_taken_i = 0; upd_pred_target_i = 0;
    do_reset();

    // Reset state
    look(32'h40);
    check("rst_pt", {31'b0, obs_pt}, 32'h0);
    check("rst_tgt", obs_tgt, 32'h44);

    // First taken branch allocates and mispredicts
    step(1, 32'h40, 1, 32'h80, 0, 32'h44, 0, 32'h40);
    check("alloc_mp", {31'b0, obs_mp}, 32'h1);
    check("alloc_rd", obs_rd, 32'h80);
    look(32'h40);
    check("alloc_pt", {31'b0, obs_pt}, 32'h1);
    check("alloc_tgt", obs_tgt, 32'h80);

    // Saturation and hysteresis
    step(1, 32'h40, 1, 32'h80, 1, 32'h80, 0, 32'h40);
    step(1, 32'h40, 1, 32'h80, 1, 32'h80, 0, 32'h40);
    step(1, 32'h40, 0, 32'h80, 1, 32'h80, 0, 32'h40);
    look(32'h40);
    check("sat_ctr2_pt", {31'b0, obs_pt}, 32'h1);
    step(1, 32'h40, 0, 32'h80, 1, 32'h80, 0, 32'h40);
    look(32'h40);
    check("sat_ctr1_pt", {31'b0, obs_pt}, 32'h0);
    check("sat_ctr1_tgt", obs_tgt, 32'h44);

    // Aliasing on index 0
    step(1, 32'h40, 1, 32'h80, 0, 32'h44, 0, 32'h80);
    check("alias_pt", {31'b0, obs_pt}, 32'h0);
    step(1, 32'h80, 1, 32'h100, 0, 32'h84, 0, 32'h40);
    look(32'h40);
    check("alias_evict", {31'b0, obs_pt}, 32'h0);

    // Target change on a hit
    step(1, 32'h40, 1, 32'h80, 0, 32'h44, 0, 32'h40);
    step(1, 32'h40, 1, 32'hC0, 1, 32'h80, 0, 32'h40);
    check("tchg_mp", {31'b0, obs_mp}, 32'h1);
    check("tchg_rd", obs_rd, 32'hC0);
    look(32'h40);
    check("tchg_tgt", obs_tgt, 32'hC0);

    // Clear beats a same-cycle update
    step(1, 32'h60, 1, 32'h200, 0, 32'h64, 1, 32'h40);
    look(32'h40);
    check("clr_40", {31'b0, obs_pt}, 32'h0);
    look(32'h60);
    check("clr_60", {31'b0, obs_pt}, 32'h0);

    // Counter wrap at 4 bits
    do_reset();
    for (int k = 0; k < 16; k++) step(1, 32'h1000 + 4 * k, 1, 32'h2000, 0, 32'h0, 0, 32'h0);
    check("wrap_b", {28'b0, branch_cnt_o}, 32'h0);
    check("wrap_m", {28'b0, mispred_cnt_o}, 32'h0);

    // Asynchronous reset between edges
    step(1, 32'h40, 1, 32'h80, 0, 32'h44, 0, 32'h40);
    step(1, 32'h40, 1, 32'h80, 1, 32'h80, 0, 32'h40);
    upd_valid_i = 0; lk_pc_i = 32'h40;
    #1 rst = 1'b1;
    #2;
    check("arst_pt", {31'b0, pred_taken_o}, 32'h0);
    check("arst_tgt", pred_target_o, 32'h44);
    check("arst_b", {28'b0, branch_cnt_o}, 32'h0);
    check("arst_m", {28'b0, mispred_cnt_o}, 32'h0);
    rst = 1'b0;
    model_reset();
    look(32'h40);

    // Randomized traffic with heavy aliasing
    for (int k = 0; k < 400; k++) begin
      pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      lp  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      tgt = $urandom_range(0, 7) << 4;
      t   = $urandom_range(0, 2) != 0;
      v   = $urandom_range(0, 3) != 0;
      c   = $urandom_range(0, 29) == 0;
      pt  = model_pt(pc);
      ptg = model_tgt(pc);
      if ($urandom_range(0, 5) == 0) pt = ~pt;
      if ($urandom_range(0, 5) == 0) ptg = $urandom;
      step(v, pc, t, tgt, pt, ptg, c, lp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
